// File: rtl/vga_pkg.sv
// Timing defaults and the control word that travels down the scan-out alignment pipe.
// Defining VGA_PIXEL_DOUBLE_EN selects a 2x2 pixel-replicated image window.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_IMG_W    = 256;
    localparam int DEF_IMG_H    = 256;
    localparam int DEF_IMG_X0   = 192;
    localparam int DEF_IMG_Y0   = 112;
    localparam int DEF_ADDR_W   = 17;
    localparam int DEF_READ_LAT = 1;
    localparam logic [7:0] DEF_BG_COLOR = 8'h00;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

`ifdef VGA_PIXEL_DOUBLE_EN
    localparam int PIX_SCALE = 2;
`else
    localparam int PIX_SCALE = 1;
`endif

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic inImg;
    } vga_ctrl_t;

    localparam vga_ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0, inImg: 1'b0};

    // End (exclusive) of a window starting at 'start', clipped to 'limit'.
    function automatic int clipEnd(input int start, input int len, input int limit);
        return (start + len < limit) ? start + len : limit;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with stage-0 decode of sync, active area,
// image window and the frame-start pulse.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int X_START  = DEF_IMG_X0,
    parameter int X_END    = DEF_IMG_X0 + DEF_IMG_W,
    parameter int Y_START  = DEF_IMG_Y0,
    parameter int Y_END    = DEF_IMG_Y0 + DEF_IMG_H
) (
    input  logic clk,
    input  logic reset,
    output logic hsRaw,
    output logic vsRaw,
    output logic active,
    output logic inImg,
    output logic frameStart
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_ON = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_NO = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] IMG_L     = HW'(X_START);
    localparam logic [HW-1:0] IMG_R     = HW'(X_END);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_ON = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_NO = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] IMG_T     = VW'(Y_START);
    localparam logic [VW-1:0] IMG_B     = VW'(Y_END);

    logic [HW-1:0] hCntReg, hCntNext;
    logic [VW-1:0] vCntReg, vCntNext;
    logic          runReg;

    // runReg holds the raster at (0,0) for one idle cycle after reset so that the
    // first scanned pixel coincides with a clean frame-start pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hCntReg <= '0;
            vCntReg <= '0;
            runReg  <= 1'b0;
        end else begin
            hCntReg <= hCntNext;
            vCntReg <= vCntNext;
            runReg  <= 1'b1;
        end
    end

    always_comb begin
        hCntNext = hCntReg;
        vCntNext = vCntReg;
        if (runReg) begin
            if (hCntReg == H_LAST) begin
                hCntNext = '0;
                vCntNext = (vCntReg == V_LAST) ? '0 : vCntReg + 1'b1;
            end else begin
                hCntNext = hCntReg + 1'b1;
            end
        end
    end

    always_comb begin
        hsRaw      = 1'b1;
        vsRaw      = 1'b1;
        active     = 1'b0;
        inImg      = 1'b0;
        frameStart = 1'b0;
        if (runReg) begin
            active     = (hCntReg < H_VIS) && (vCntReg < V_VIS);
            hsRaw      = !((hCntReg >= H_SYNC_ON) && (hCntReg < H_SYNC_NO));
            vsRaw      = !((vCntReg >= V_SYNC_ON) && (vCntReg < V_SYNC_NO));
            inImg      = active && (hCntReg >= IMG_L) && (hCntReg < IMG_R)
                                && (vCntReg >= IMG_T) && (vCntReg < IMG_B);
            frameStart = (hCntReg == '0) && (vCntReg == '0);
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: raster timing, framebuffer address generation and sync/pixel alignment.
// Defining VGA_PIXEL_DOUBLE_EN maps each framebuffer pixel onto a 2x2 screen block.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int IMG_X0   = DEF_IMG_X0,
    parameter int IMG_Y0   = DEF_IMG_Y0,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = DEF_READ_LAT,
    parameter logic [7:0] BG_COLOR = DEF_BG_COLOR
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] address_vga,
    input  logic [7:0]        color,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              frame_start
);

    localparam int X_END  = clipEnd(IMG_X0, IMG_W * PIX_SCALE, H_ACTIVE);
    localparam int Y_END  = clipEnd(IMG_Y0, IMG_H * PIX_SCALE, V_ACTIVE);
    localparam int PIPE_D = READ_LAT + 1;

    logic      hsRaw, vsRaw, active, inImg;
    vga_ctrl_t ctrl0;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .X_START(IMG_X0), .X_END(X_END), .Y_START(IMG_Y0), .Y_END(Y_END)
    ) uTiming (
        .clk        (clk),
        .reset      (reset),
        .hsRaw      (hsRaw),
        .vsRaw      (vsRaw),
        .active     (active),
        .inImg      (inImg),
        .frameStart (frame_start)
    );

    assign ctrl0 = '{hs: hsRaw, vs: vsRaw, active: active, inImg: inImg};

    // Address generation: incremental row base plus column, no multiplier.
    logic [ADDR_W-1:0] rowBaseReg, colReg, addrReg;
    logic              prevInImgReg, colPhaseReg, rowPhaseReg;
    logic              lineEnd, colStep, rowStep;

    assign lineEnd = prevInImgReg && !inImg;

`ifdef VGA_PIXEL_DOUBLE_EN
    assign colStep = colPhaseReg;
    assign rowStep = rowPhaseReg;
`else
    assign colStep = 1'b1;
    assign rowStep = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rowBaseReg   <= '0;
            colReg       <= '0;
            addrReg      <= '0;
            prevInImgReg <= 1'b0;
            colPhaseReg  <= 1'b0;
            rowPhaseReg  <= 1'b0;
        end else begin
            prevInImgReg <= inImg;
            addrReg      <= inImg ? rowBaseReg + colReg : '0;

            if (!inImg) begin
                colReg      <= '0;
                colPhaseReg <= 1'b0;
            end else begin
                colPhaseReg <= !colPhaseReg;
                if (colStep)
                    colReg <= colReg + 1'b1;
            end

            if (frame_start) begin
                rowBaseReg  <= '0;
                rowPhaseReg <= 1'b0;
            end else if (lineEnd) begin
                rowPhaseReg <= !rowPhaseReg;
                if (rowStep)
                    rowBaseReg <= rowBaseReg + ADDR_W'(IMG_W);
            end
        end
    end

    assign address_vga = addrReg;

    // Control pipe matching the address register plus the memory read latency.
    vga_ctrl_t pipeTap [PIPE_D+1];
    assign pipeTap[0] = ctrl0;

    generate
        for (genvar gi = 0; gi < PIPE_D; gi++) begin : gPipe
            vga_ctrl_t stageReg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    stageReg <= CTRL_IDLE;
                else
                    stageReg <= pipeTap[gi];
            end
            assign pipeTap[gi+1] = stageReg;
        end
    endgenerate

    vga_ctrl_t  ctrlOut;
    logic [7:0] pixNext, pixReg;
    logic       hsReg, vsReg, blankReg;

    assign ctrlOut = pipeTap[PIPE_D];

    always_comb begin
        pixNext = 8'h00;
        if (ctrlOut.inImg)
            pixNext = color;
        else if (ctrlOut.active)
            pixNext = BG_COLOR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixReg   <= 8'h00;
            hsReg    <= 1'b1;
            vsReg    <= 1'b1;
            blankReg <= 1'b0;
        end else begin
            pixReg   <= pixNext;
            hsReg    <= ctrlOut.hs;
            vsReg    <= ctrlOut.vs;
            blankReg <= ctrlOut.active;
        end
    end

    assign vga_r       = pixReg;
    assign vga_g       = pixReg;
    assign vga_b       = pixReg;
    assign vga_hs      = hsReg;
    assign vga_vs      = vsReg;
    assign vga_blank_n = blankReg;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with a shortened vertical raster (27 lines) and a
// 1-cycle memory model returning address[7:0]; honours VGA_PIXEL_DOUBLE_EN.
module tb_vga_scanout;

    localparam int HT    = 800;
    localparam int VA    = 20;
    localparam int VT    = 27;
    localparam int FRAME = HT * VT;
    localparam int LAT   = 3;
    localparam int X0    = 192;
    localparam int Y0    = 8;
    localparam int IW    = 256;
    localparam int IH    = 8;
`ifdef VGA_PIXEL_DOUBLE_EN
    localparam int SC = 2;
    localparam int P193 = 0, P194 = 1, A192_9 = 0, P200_9 = 4;
    localparam int LX = 639, LY = 19, LADDR = 1503;
`else
    localparam int SC = 1;
    localparam int P193 = 1, P194 = 2, A192_9 = 256, P200_9 = 8;
    localparam int LX = 447, LY = 15, LADDR = 2047;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [16:0] address_vga;
    logic [7:0]  color = 8'h00;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

    vga_scanout #(
        .V_ACTIVE(VA), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .IMG_H(IH), .IMG_Y0(Y0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address_vga (address_vga),
        .color       (color),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Framebuffer stand-in: one-cycle read latency, data = low address byte.
    always @(posedge clk) color <= address_vga[7:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nVec = 0;
    int nMis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic int expAddr(input int x, input int y);
        int xe, ye;
        xe = (X0 + IW * SC < 640) ? X0 + IW * SC : 640;
        ye = (Y0 + IH * SC < VA) ? Y0 + IH * SC : VA;
        if (x < X0 || x >= xe || y < Y0 || y >= ye)
            return -1;
        return ((y - Y0) / SC) * IW + (x - X0) / SC;
    endfunction

    // Frame monitor: compares every output pixel of one frame against the model.
    int fsCyc = 0;
    int fs2Cyc, hsLow0, hsFirst0, blank0, blankLines, blankCyc, vsFirst, vsLowCyc;
    int fsCount, pixErr, sigErr;
    bit monOn = 1'b0;

    task automatic resetStats();
        fs2Cyc = -1; hsLow0 = 0; hsFirst0 = -1; blank0 = 0; blankLines = 0;
        blankCyc = 0; vsFirst = -1; vsLowCyc = 0; fsCount = 0; pixErr = 0; sigErr = 0;
    endtask

    always @(negedge clk) begin : monitor
        int p, x, y, ea, off;
        logic [7:0] er;
        logic eb, eh, ev;
        if (monOn) begin
            off = cyc - fsCyc;
            if (frame_start && off >= 0 && off < FRAME) fsCount++;
            if (frame_start && off > 0 && fs2Cyc < 0) fs2Cyc = cyc;
            p = off - LAT;
            if (p >= 0 && p < FRAME) begin
                x  = p % HT;
                y  = p / HT;
                ea = expAddr(x, y);
                er = (ea >= 0) ? ea[7:0] : 8'h00;
                eb = (x < 640) && (y < VA);
                eh = !((x >= 656) && (x < 752));
                ev = !((y >= 22) && (y < 24));
                if (vga_blank_n !== eb || vga_hs !== eh || vga_vs !== ev) sigErr++;
                if (vga_r !== er || vga_g !== er || vga_b !== er) pixErr++;
                if (y == 0 && vga_hs === 1'b0) begin
                    hsLow0++;
                    if (hsFirst0 < 0) hsFirst0 = off;
                end
                if (y == 0 && vga_blank_n === 1'b1) blank0++;
                if (vga_blank_n === 1'b1) blankCyc++;
                if (x == 0 && vga_blank_n === 1'b1) blankLines++;
                if (vga_vs === 1'b0) begin
                    vsLowCyc++;
                    if (vsFirst < 0) vsFirst = y;
                end
            end
        end
    end

    task automatic waitTo(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic waitFs(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic pixAt(input int x, input int y);
        waitTo(fsCyc + y * HT + x + LAT);
    endtask

    task automatic addrAt(input int x, input int y);
        waitTo(fsCyc + y * HT + x + 1);
    endtask

    initial begin : watchdog
        #700000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        bit found;

        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_blank", vga_blank_n, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_addr", address_vga, 0);
        check("rst_fs", frame_start, 0);
        check("sync_n", vga_sync_n, 0);

        reset = 1'b1;
        waitFs(10, found);
        check("fs_after_rst", found, 1);
        fsCyc = cyc;
        resetStats();
        monOn = 1'b1;

        pixAt(100, 5);
        check("bg_pix_100_5", vga_r, 0);
        check("blank_100_5", vga_blank_n, 1);
        addrAt(X0, Y0);
        check("addr_192_8", address_vga, 0);
        pixAt(X0, Y0);
        check("pix_192_8", vga_g, 0);
        pixAt(X0 + 1, Y0);
        check("pix_193_8", vga_b, P193);
        pixAt(X0 + 2, Y0);
        check("pix_194_8", vga_r, P194);
        addrAt(X0, Y0 + 1);
        check("addr_192_9", address_vga, A192_9);
        pixAt(X0 + 8, Y0 + 1);
        check("pix_200_9", vga_r, P200_9);
        addrAt(LX, LY);
        check("addr_last", address_vga, LADDR);
        pixAt(LX, LY);
        check("pix_last", vga_r, LADDR % 256);
        addrAt(300, 21);
        check("addr_vblank", address_vga, 0);

        waitTo(fsCyc + FRAME + LAT + 1);
        monOn = 1'b0;
        check("hs_low_len", hsLow0, 96);
        check("hs_start", hsFirst0, 656 + LAT);
        check("blank_line", blank0, 640);
        check("blank_lines", blankLines, VA);
        check("blank_total", blankCyc, 640 * VA);
        check("vs_start_line", vsFirst, 22);
        check("vs_low_len", vsLowCyc, 2 * HT);
        check("fs_per_frame", fsCount, 1);
        check("fs_period", fs2Cyc - fsCyc, FRAME);
        check("frame_sig_err", sigErr, 0);
        check("frame_pix_err", pixErr, 0);

        // Mid-frame reset at line 12, x = 400 (inside the visible area).
        waitTo(fs2Cyc + 12 * HT + 400);
        reset = 1'b0;
        #1;
        check("midrst_blank", vga_blank_n, 0);
        check("midrst_hs", vga_hs, 1);
        check("midrst_addr", address_vga, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        waitFs(10, found);
        check("fs_after_midrst", found, 1);
        fsCyc = cyc;
        resetStats();
        monOn = 1'b1;
        addrAt(X0, Y0);
        check("restart_addr", address_vga, 0);
        waitTo(fsCyc + FRAME + LAT + 1);
        monOn = 1'b0;
        check("restart_hs_start", hsFirst0, 656 + LAT);
        check("restart_vs_start", vsFirst, 22);
        check("restart_fs_cnt", fsCount, 1);
        check("restart_sig_err", sigErr, 0);
        check("restart_pix_err", pixErr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
